// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state encoding, width helpers and burst-length clamp for the bus sequencer.
package bus_arb_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    XFER    = 2'd1,
    RELEASE = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction

  function automatic int len_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  // Zero-length requests still move one beat; oversize requests are capped.
  function automatic int clamp_len(input int raw, input int max_burst);
    return raw == 0 ? 1 : (raw > max_burst ? max_burst : raw);
  endfunction
endpackage

// File: rtl/onehot_to_index.sv
// onehot_to_index: index of the set bit, valid only when exactly one bit is set.
module onehot_to_index #(
  parameter int N = 4,
  localparam int W = N > 1 ? $clog2(N) : 1
) (
  input  logic [N-1:0] in_i,
  output logic [W-1:0] idx_o,
  output logic         valid_o
);
  always_comb begin
    idx_o = '0;
    for (int k = 0; k < N; k++) idx_o = in_i[k] ? idx_o | W'(k) : idx_o;
    valid_o = in_i != '0 && (in_i & (in_i - N'(1))) == '0;
  end
endmodule

// File: rtl/bus_txn_sequencer.sv
// bus_txn_sequencer: locks the bus to the granted client, moves its burst to the server,
// aborts on stall timeout or request withdrawal, then pulses a release to the arbiter.
module bus_txn_sequencer
  import bus_arb_pkg::*;
#(
  parameter int NUM_CLIENTS    = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_BURST      = 8,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int ID_W  = idx_w(NUM_CLIENTS),
  localparam int LEN_W = len_w(MAX_BURST)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CLIENTS-1:0]            arb_grant,
  input  logic                              arb_grant_valid,
  output logic                              arb_release,
  input  logic [NUM_CLIENTS-1:0]            cl_req,
  input  logic [NUM_CLIENTS*LEN_W-1:0]      cl_burst_len,
  input  logic [NUM_CLIENTS-1:0]            cl_valid,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cl_data,
  output logic [NUM_CLIENTS-1:0]            cl_ready,
  output logic                              srv_valid,
  output logic [DATA_WIDTH-1:0]             srv_data,
  output logic [ID_W-1:0]                   srv_id,
  output logic                              srv_last,
  input  logic                              srv_ready,
  output logic                              busy,
  output logic                              timeout_err
);
  localparam int ST_W = idx_w(TIMEOUT_CYCLES);

  state_e                state_q, state_d;
  logic [ID_W-1:0]       owner_q, gnt_idx;
  logic                  gnt_ok;
  logic [LEN_W-1:0]      len_q, beat_q;
  logic [ST_W-1:0]       stall_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  tout_q;
  logic [DATA_WIDTH-1:0] data_a [NUM_CLIENTS];
  logic [LEN_W-1:0]      blen_a [NUM_CLIENTS];
  logic                  xfer, cur_valid, beat, at_last, start, tmo, drop;

  genvar i;
  for (i = 0; i < NUM_CLIENTS; i++) begin : g_unpack
    assign data_a[i] = cl_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign blen_a[i] = cl_burst_len[i*LEN_W +: LEN_W];
  end

  onehot_to_index #(.N(NUM_CLIENTS)) u_gnt_dec (
    .in_i   (arb_grant),
    .idx_o  (gnt_idx),
    .valid_o(gnt_ok)
  );

  assign xfer      = state_q == XFER;
  assign cur_valid = cl_valid[owner_q];
  assign beat      = xfer && cur_valid && srv_ready;
  assign at_last   = beat_q == len_q - LEN_W'(1);
  assign start     = state_q == IDLE && arb_grant_valid && gnt_ok && cl_req[gnt_idx];
  // A beat on the same edge always wins, so a last beat with cl_req dropping completes normally.
  assign tmo       = xfer && !beat && stall_q == ST_W'(TIMEOUT_CYCLES - 1);
  assign drop      = xfer && !beat && !cl_req[owner_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q == IDLE ? (start ? XFER : IDLE)
            : state_q == XFER ? ((beat && at_last) || tmo || drop ? RELEASE : XFER)
            : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= '0;
      len_q   <= LEN_W'(1);
      beat_q  <= '0;
      stall_q <= '0;
      data_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      tout_q <= tmo;
      if (start) begin
        owner_q <= gnt_idx;
        len_q   <= LEN_W'(clamp_len(int'(blen_a[gnt_idx]), MAX_BURST));
        beat_q  <= '0;
        stall_q <= '0;
      end else if (xfer) begin
        beat_q  <= beat_q + LEN_W'(beat);
        stall_q <= beat ? '0 : stall_q + ST_W'(1);
        data_q  <= data_a[owner_q];
      end
    end
  end

  always_comb begin
    busy        = state_q != IDLE;
    arb_release = state_q == RELEASE;
    srv_valid   = xfer && cur_valid;
    srv_last    = srv_valid && at_last;
    srv_data    = xfer ? data_a[owner_q] : data_q;
    srv_id      = owner_q;
    cl_ready    = xfer && srv_ready ? NUM_CLIENTS'(1) << owner_q : '0;
    timeout_err = tout_q;
  end
endmodule

// File: tb/tb_bus_txn_sequencer.sv
// tb_bus_txn_sequencer: directed vectors with hand-computed expectations for bus_txn_sequencer.
module tb_bus_txn_sequencer;
  localparam int NC = 4, DW = 8, MB = 8, TO = 16, IW = 2, LW = 4;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic [NC-1:0]   arb_grant, cl_req, cl_valid, cl_ready;
  logic            arb_grant_valid, arb_release, srv_valid, srv_last, srv_ready, busy, timeout_err;
  logic [NC*LW-1:0] cl_burst_len;
  logic [NC*DW-1:0] cl_data;
  logic [DW-1:0]   srv_data;
  logic [IW-1:0]   srv_id;
  int errors = 0, checks = 0;

  bus_txn_sequencer #(.NUM_CLIENTS(NC), .DATA_WIDTH(DW), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .arb_grant(arb_grant), .arb_grant_valid(arb_grant_valid),
    .arb_release(arb_release), .cl_req(cl_req), .cl_burst_len(cl_burst_len), .cl_valid(cl_valid),
    .cl_data(cl_data), .cl_ready(cl_ready), .srv_valid(srv_valid), .srv_data(srv_data),
    .srv_id(srv_id), .srv_last(srv_last), .srv_ready(srv_ready), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [7:0] data_of(input int c);
    return 8'(8'h11 * (c + 1));
  endfunction

  task automatic idle_outputs(input string tag);
    check({tag, "/busy"}, 32'(busy), 0);
    check({tag, "/release"}, 32'(arb_release), 0);
    check({tag, "/srv_valid"}, 32'(srv_valid), 0);
    check({tag, "/srv_last"}, 32'(srv_last), 0);
    check({tag, "/cl_ready"}, 32'(cl_ready), 0);
    check({tag, "/timeout"}, 32'(timeout_err), 0);
  endtask

  task automatic grant(input int c, input int len);
    arb_grant = NC'(1 << c);
    arb_grant_valid = 1'b1;
    cl_req = NC'(1 << c);
    cl_burst_len[c*LW +: LW] = LW'(len);
    #1;
    check("grant/busy_before", 32'(busy), 0);
    tick;
    arb_grant_valid = 1'b0;
    arb_grant = '0;
  endtask

  task automatic run_burst(input int c, input int len, input int exp_n);
    srv_ready = 1'b1;
    cl_valid = '1;
    grant(c, len);
    for (int k = 0; k < exp_n; k++) begin
      check($sformatf("burst%0d/valid%0d", c, k), 32'(srv_valid), 1);
      check($sformatf("burst%0d/id%0d", c, k), 32'(srv_id), 32'(c));
      check($sformatf("burst%0d/data%0d", c, k), 32'(srv_data), 32'(data_of(c)));
      check($sformatf("burst%0d/last%0d", c, k), 32'(srv_last), 32'(k == exp_n - 1));
      check($sformatf("burst%0d/ready%0d", c, k), 32'(cl_ready), 32'(1 << c));
      tick;
    end
    check("burst/release", 32'(arb_release), 1);
    check("burst/timeout", 32'(timeout_err), 0);
    check("burst/valid_off", 32'(srv_valid), 0);
    check("burst/ready_off", 32'(cl_ready), 0);
    check("burst/data_hold", 32'(srv_data), 32'(data_of(c)));
    tick;
    idle_outputs("burst_done");
    cl_req = '0;
  endtask

  logic [NC-1:0] bad_gnt [3];
  logic [NC-1:0] bad_req [3];

  initial begin
    arb_grant = '0; arb_grant_valid = 1'b0; cl_req = '0; cl_burst_len = '0;
    cl_valid = '0; cl_data = 32'h44332211; srv_ready = 1'b0;
    bad_gnt = '{4'b0110, 4'b0000, 4'b1000};
    bad_req = '{4'b1111, 4'b1111, 4'b0111};
    #12;
    idle_outputs("reset");
    check("reset/srv_data", 32'(srv_data), 0);
    check("reset/srv_id", 32'(srv_id), 0);
    rst_n = 1'b1;
    tick;

    run_burst(1, 3, 3);

    for (int t = 0; t < 3; t++) begin
      arb_grant = bad_gnt[t];
      cl_req = bad_req[t];
      arb_grant_valid = 1'b1;
      tick;
      idle_outputs($sformatf("badgnt%0d_a", t));
      tick;
      idle_outputs($sformatf("badgnt%0d_b", t));
    end
    arb_grant_valid = 1'b0; arb_grant = '0; cl_req = '0;

    run_burst(0, 0, 1);
    run_burst(2, 15, 8);
    run_burst(3, 8, 8);

    cl_valid = '1;
    srv_ready = 1'b0;
    grant(3, 2);
    for (int k = 0; k < TO; k++) begin
      check($sformatf("tmo/busy%0d", k), 32'(busy), 1);
      check($sformatf("tmo/release%0d", k), 32'(arb_release), 0);
      check($sformatf("tmo/err%0d", k), 32'(timeout_err), 0);
      check($sformatf("tmo/last%0d", k), 32'(srv_last), 0);
      tick;
    end
    check("tmo/release", 32'(arb_release), 1);
    check("tmo/err", 32'(timeout_err), 1);
    check("tmo/last", 32'(srv_last), 0);
    tick;
    idle_outputs("tmo_done");
    cl_req = '0;

    srv_ready = 1'b1;
    grant(1, 4);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("drop/last%0d", k), 32'(srv_last), 0);
      tick;
    end
    cl_req = '0;
    srv_ready = 1'b0;
    #1;
    check("drop/busy", 32'(busy), 1);
    tick;
    check("drop/release", 32'(arb_release), 1);
    check("drop/err", 32'(timeout_err), 0);
    tick;
    idle_outputs("drop_done");

    srv_ready = 1'b1;
    grant(2, 2);
    check("droplast/last0", 32'(srv_last), 0);
    tick;
    cl_req = '0;
    #1;
    check("droplast/last1", 32'(srv_last), 1);
    check("droplast/ready", 32'(cl_ready), 32'b0100);
    tick;
    check("droplast/release", 32'(arb_release), 1);
    check("droplast/err", 32'(timeout_err), 0);
    tick;
    idle_outputs("droplast_done");

    grant(2, 4);
    check("rst/valid_before", 32'(srv_valid), 1);
    tick;
    #1;
    rst_n = 1'b0;
    #1;
    idle_outputs("rst_async");
    check("rst/srv_data", 32'(srv_data), 0);
    check("rst/srv_id", 32'(srv_id), 0);
    cl_req = '0;
    tick;
    rst_n = 1'b1;
    tick;
    idle_outputs("rst_after1");
    tick;
    idle_outputs("rst_after2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
